conv_seq_ctrl: RTL
==================

Name: conv_seq_ctrl

Overview:
- Sequencer for the 1-D convolution datapath: X buffer, F ROM, one MAC unit and the Y output slave.
- Once the X buffer reports full, it computes N-M+1 outputs y[j]. For each output it:
  - clears the MAC,
  - issues M address pairs (x_addr = j+k, f_addr = k),
  - tracks the MAC pipeline until the sum settles,
  - presents the sum through a valid/ready handshake.
- Emits a one-cycle done pulse after the last output is accepted. The convolution top uses that pulse to recycle the X buffer.

Parameters:
- N, 128, X vector length; legal range N >= M.
- M, 32, filter length; legal range M >= 1.
- MAC_LAT, 2, cycles from address issue to accumulator-enable (1 memory read + 1 multiply register); legal range MAC_LAT >= 1.
- X_AW, $clog2(N), X address width.
- F_AW, $clog2(M) (1 if M==1), F address width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset: asynchronous, active-high.
- start  in  1  level: X buffer full; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- x_addr  out  X_AW  X buffer read address.
- f_addr  out  F_AW  F ROM read address.
- mac_clr  out  1  clears the multiply and adder registers.
- mac_en_mult  out  1  multiply-register enable.
- mac_en_acc  out  1  adder-register enable.
- y_valid  out  1  MAC result valid toward the Y buffer.
- y_ready  in  1  Y buffer can accept.
- y_idx  out  X_AW  index j of the current output.
- done  out  1  one-cycle pulse: convolution complete.

Behaviour:
- Reset (asynchronous assert; synchronous release on clk):
  - state IDLE; base j=0; tap counter k=0; pipe shift register cleared.
  - All outputs 0.
  - Reset mid-operation abandons the current output with no done pulse.
- States: IDLE, CLR, ISSUE, DRAIN, OUT, FIN. All outputs are registered or decoded from state and counters only; there is no combinational input-to-output path.
- IDLE: when start=1 at an edge, go to CLR with j=0.
- CLR (1 cycle): mac_clr=1, k=0, then go to ISSUE.
- ISSUE (exactly M cycles):
  - x_addr=j+k, f_addr=k; k increments each cycle.
  - A 1 is shifted into pipe[0] each cycle.
  - Leave for DRAIN when k==M-1.
- Pipeline enables:
  - mac_en_mult = pipe[0], so it is high 1 cycle after each issue.
  - mac_en_acc = pipe[MAC_LAT-1].
  - Enables therefore continue through DRAIN.
- DRAIN: lasts exactly MAC_LAT cycles until the pipe is empty, then go to OUT.
- OUT:
  - y_valid=1 and is held until y_ready=1 at an edge. It must not drop while waiting. y_ready seen outside OUT has no effect.
  - On acceptance: if j==N-M, go to FIN; otherwise j++ and go to CLR.
- FIN (1 cycle): done=1, j=0, then go to IDLE.
- start is ignored outside IDLE. If start is still high in the cycle after FIN, a new pass begins.
- Timing, with start sampled at cycle 0:
  - CLR is cycle 1; ISSUE is cycles 2..M+1; DRAIN is cycles M+2..M+MAC_LAT+1.
  - First y_valid at cycle M+MAC_LAT+2 (36 with defaults).
  - Minimum period per output is M+MAC_LAT+2 cycles.
- Address bounds: x_addr never exceeds N-1 and f_addr never exceeds M-1, so no wrap is ever required.
- y_idx=j, stable from CLR through OUT.

Decomposition:
- Package conv_ctrl_pkg:
  - state enum conv_state_e {IDLE, CLR, ISSUE, DRAIN, OUT, FIN};
  - helper function for address widths;
  - default constants for N, M, MAC_LAT.
- Sub-module ctrl_valid_pipe:
  - parameterised MAC_LAT-deep shift register with async reset;
  - input: issue strobe;
  - outputs: mac_en_mult, mac_en_acc, and an empty flag that drives the DRAIN exit.

Test Plan:
- Defaults; start held at 1; y_ready tied to 1.
  - Required: y_valid first at cycle 36.
  - Exactly 97 y_valid handshakes, with y_idx 0..96.
  - done pulses once, 1 cycle after the 97th handshake; busy then goes to 0.
- N=8, M=3, MAC_LAT=2; check each ISSUE window.
  - Required for j=2: x_addr 2,3,4 with f_addr 0,1,2.
  - mac_en_mult high for 3 cycles, lagging issue by 1; mac_en_acc lags issue by 2.
  - mac_clr high exactly 1 cycle before each window.
- Backpressure: hold y_ready=0 for 10 cycles in OUT at j=5.
  - Required: y_valid stays 1, y_idx stays 5, x_addr/f_addr frozen, no enables asserted.
  - Advance occurs only on the edge where y_ready=1.
- Boundary N=M=4.
  - Required: one output only, y_idx=0, x_addr 0..3, then done.
- Boundary M=1.
  - Required: ISSUE lasts 1 cycle; N outputs with x_addr=j, f_addr=0.
- Assert reset asynchronously mid-ISSUE at j=40, k=7.
  - Required: immediately state IDLE, all outputs 0, no done pulse.
  - After release with start=1: restarts at j=0, first y_valid at cycle 36.

Source files
------------

// File: rtl/conv_seq_ctrl_pkg.sv
// Shared definitions for the 1-D convolution sequencer: controller states,
// default geometry and the address-width helper.
package conv_ctrl_pkg;

  // Default geometry of the convolution datapath.
  localparam int DEF_N       = 128;
  localparam int DEF_M       = 32;
  localparam int DEF_MAC_LAT = 2;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ISSUE,
    DRAIN,
    OUT,
    FIN
  } conv_state_e;

  // Address width for a memory of the given depth. A depth of one still
  // needs a one-bit address so that no port collapses to zero width.
  function automatic int addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Bundle of the sequencer's control, address and Y-handshake signals.
// The master side is the sequencer; the slave side is the datapath.
interface conv_seq_ctrl_if
  import conv_ctrl_pkg::*;
#(
  parameter int X_AW = addr_width(DEF_N),
  parameter int F_AW = addr_width(DEF_M)
);

  logic            start;
  logic            busy;
  logic [X_AW-1:0] x_addr;
  logic [F_AW-1:0] f_addr;
  logic            mac_clr;
  logic            mac_en_mult;
  logic            mac_en_acc;
  logic            y_valid;
  logic            y_ready;
  logic [X_AW-1:0] y_idx;
  logic            done;

  modport master (
    input  start,
    input  y_ready,
    output busy,
    output x_addr,
    output f_addr,
    output mac_clr,
    output mac_en_mult,
    output mac_en_acc,
    output y_valid,
    output y_idx,
    output done
  );

  modport slave (
    output start,
    output y_ready,
    input  busy,
    input  x_addr,
    input  f_addr,
    input  mac_clr,
    input  mac_en_mult,
    input  mac_en_acc,
    input  y_valid,
    input  y_idx,
    input  done
  );

endinterface

// File: rtl/conv_seq_ctrl_valid_pipe.sv
// Tracks which issued address pairs are still travelling through the MAC.
// One bit per pipeline stage: stage 0 lines up with the multiply register,
// the last stage lines up with the accumulator register.
module ctrl_valid_pipe #(
  parameter int MAC_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  output logic mac_en_mult,
  output logic mac_en_acc,
  output logic empty
);

  logic [MAC_LAT-1:0] pipe;

  generate
    if (MAC_LAT == 1) begin : g_single
      // Single stage: the issue strobe is simply delayed by one cycle.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) pipe <= '0;
        else       pipe <= issue;
      end
      // Nothing sits upstream of the only stage, so after this cycle the
      // pipe holds only what is issued now.
      assign empty = 1'b1;
    end else begin : g_multi
      // Shift a one in for every issued address pair.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) pipe <= '0;
        else       pipe <= {pipe[MAC_LAT-2:0], issue};
      end
      // High when only the last stage can still be occupied, i.e. the
      // current cycle is the final accumulate of the output in flight.
      assign empty = ~|pipe[MAC_LAT-2:0];
    end
  endgenerate

  assign mac_en_mult = pipe[0];
  assign mac_en_acc  = pipe[MAC_LAT-1];

endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the 1-D convolution datapath. Once the X buffer is full it
// walks every output position j, clears the MAC, issues M address pairs,
// waits for the MAC pipeline to drain and hands the sum to the Y buffer
// over a valid/ready handshake. A one-cycle done pulse follows the last
// accepted output so the X buffer can be recycled.
module conv_seq_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int M       = DEF_M,
  parameter int MAC_LAT = DEF_MAC_LAT,
  parameter int X_AW    = addr_width(N),
  parameter int F_AW    = addr_width(M)
) (
  input  logic           clk,
  input  logic           reset,
  conv_seq_ctrl_if.master bus
);

  // Last tap index inside one output, and last output position.
  localparam logic [F_AW-1:0] K_LAST = F_AW'(M - 1);
  localparam logic [X_AW-1:0] J_LAST = X_AW'(N - M);

  conv_state_e     state;
  conv_state_e     state_nxt;
  logic [X_AW-1:0] j;
  logic [X_AW-1:0] j_nxt;
  logic [F_AW-1:0] k;
  logic [F_AW-1:0] k_nxt;
  logic            issue;
  logic            pipe_empty;

  // State, output position and tap counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      j     <= '0;
      k     <= '0;
    end else begin
      state <= state_nxt;
      j     <= j_nxt;
      k     <= k_nxt;
    end
  end

  // Next-state logic: walk CLR -> ISSUE -> DRAIN -> OUT for every j.
  always_comb begin
    state_nxt = state;
    j_nxt     = j;
    k_nxt     = k;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = CLR;
          j_nxt     = '0;
        end
      end
      CLR: begin
        k_nxt     = '0;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        if (k == K_LAST) begin
          k_nxt     = '0;
          state_nxt = DRAIN;
        end else begin
          k_nxt = k + F_AW'(1);
        end
      end
      DRAIN: begin
        if (pipe_empty) state_nxt = OUT;
      end
      OUT: begin
        if (bus.y_ready) begin
          if (j == J_LAST) begin
            j_nxt     = '0;
            state_nxt = FIN;
          end else begin
            j_nxt     = j + X_AW'(1);
            state_nxt = CLR;
          end
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        j_nxt     = '0;
        k_nxt     = '0;
      end
    endcase
  end

  // Outputs are decoded from state and counters only; addresses are
  // parked at zero outside ISSUE so they stay frozen while waiting in OUT.
  always_comb begin
    bus.busy    = (state != IDLE);
    bus.mac_clr = (state == CLR);
    bus.y_valid = (state == OUT);
    bus.done    = (state == FIN);
    bus.y_idx   = j;
    bus.x_addr  = '0;
    bus.f_addr  = '0;
    if (state == ISSUE) begin
      bus.x_addr = j + X_AW'(k);
      bus.f_addr = k;
    end
  end

  ctrl_valid_pipe #(
    .MAC_LAT (MAC_LAT)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .issue       (issue),
    .mac_en_mult (bus.mac_en_mult),
    .mac_en_acc  (bus.mac_en_acc),
    .empty       (pipe_empty)
  );

endmodule
